// File: rtl/lsu_mem_sequencer_if.sv
// Core-side request/response port and data-memory bus port of the LSU sequencer.
// Member names carry the direction of the signal as seen by the sequencer.
interface lsu_core_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [1:0]      req_size_i;
  logic            req_unsigned_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;

  // Request: transfer when req_valid_i && req_ready_o on a rising edge; no backpressure on rsp.
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

interface lsu_bus_if #(
  parameter int XLEN = 32,
  parameter int NB   = XLEN / 8
) ();
  logic            mem_req_o;
  logic            mem_gnt_i;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [NB-1:0]   mem_be_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: aligns one core access onto a req/gnt/rvalid word bus,
// splitting word-crossing accesses into two beats and merging/extending load data.
module lsu_mem_sequencer #(
  parameter int XLEN = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lsu_core_if.slave  core,
  lsu_bus_if.master  bus,
  output logic       busy_o,
  output logic [2:0] dbg_state_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, uns_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata0_q, rdata1_q;

  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]   mem_be_q, mem_be_d;

  logic            accept;
  logic            eff_we;
  logic [1:0]      eff_size;
  logic [XLEN-1:0] eff_addr, eff_wdata, aligned;
  logic [OW-1:0]   off;
  logic [OW:0]     nbytes;
  logic            split;
  logic [NB-1:0]   base_be;
  logic [2*NB-1:0] be_wide;
  logic [2*XLEN-1:0] wdata_wide;
  logic [XLEN-1:0] raw, ext;

  assign accept = core.req_valid_i && (state_q == IDLE);

  // Beat fields come from the live request in the accept cycle, else from the capture.
  always_comb begin
    eff_we    = accept ? core.req_we_i    : we_q;
    eff_size  = accept ? core.req_size_i  : size_q;
    eff_addr  = accept ? core.req_addr_i  : addr_q;
    eff_wdata = accept ? core.req_wdata_i : wdata_q;
    off       = eff_addr[OW-1:0];
    aligned   = {eff_addr[XLEN-1:OW], {OW{1'b0}}};
    case (eff_size)
      2'd0:    nbytes = (OW+1)'(1);
      2'd1:    nbytes = (OW+1)'(2);
      default: nbytes = (OW+1)'(NB);
    endcase
    split = ({1'b0, off} + nbytes) > (OW+1)'(NB);
    for (int i = 0; i < NB; i++) base_be[i] = (i < int'(nbytes));
    // The upper half of each widened vector is exactly what spills into beat1.
    be_wide    = {{NB{1'b0}}, base_be} << off;
    wdata_wide = {{XLEN{1'b0}}, eff_wdata} << {off, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (core.req_valid_i) state_d = (core.req_size_i == 2'd3) ? RESP : REQ0;
      REQ0:    if (bus.mem_gnt_i) state_d = WAIT0;
      WAIT0:   if (bus.mem_rvalid_i) state_d = split ? REQ1 : RESP;
      REQ1:    if (bus.mem_gnt_i) state_d = WAIT1;
      WAIT1:   if (bus.mem_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_be_d    = '0;
    mem_wdata_d = '0;
    if (state_d == REQ0) begin
      mem_req_d   = 1'b1;
      mem_we_d    = eff_we;
      mem_addr_d  = aligned;
      mem_be_d    = be_wide[NB-1:0];
      mem_wdata_d = wdata_wide[XLEN-1:0];
    end else if (state_d == REQ1) begin
      mem_req_d   = 1'b1;
      mem_we_d    = eff_we;
      mem_addr_d  = aligned + XLEN'(NB);
      mem_be_d    = be_wide[2*NB-1:NB];
      mem_wdata_d = wdata_wide[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if (accept) begin
        we_q     <= core.req_we_i;
        uns_q    <= core.req_unsigned_i;
        size_q   <= core.req_size_i;
        addr_q   <= core.req_addr_i;
        wdata_q  <= core.req_wdata_i;
        rdata0_q <= '0;
        rdata1_q <= '0;
      end
      if (state_q == WAIT0 && bus.mem_rvalid_i) rdata0_q <= bus.mem_rdata_i;
      if (state_q == WAIT1 && bus.mem_rvalid_i) rdata1_q <= bus.mem_rdata_i;
    end
  end

  always_comb begin
    raw = XLEN'({rdata1_q, rdata0_q} >> {addr_q[OW-1:0], 3'b000});
    case (size_q)
      2'd0:    ext = uns_q ? {{(XLEN-8){1'b0}}, raw[7:0]}   : {{(XLEN-8){raw[7]}}, raw[7:0]};
      2'd1:    ext = uns_q ? {{(XLEN-16){1'b0}}, raw[15:0]} : {{(XLEN-16){raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  assign core.req_ready_o = (state_q == IDLE);
  assign core.rsp_valid_o = (state_q == RESP);
  assign core.rsp_err_o   = (state_q == RESP) && (size_q == 2'd3);
  assign core.rsp_rdata_o = ((state_q == RESP) && !we_q && (size_q != 2'd3)) ? ext : '0;

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_wdata_o = mem_wdata_q;

  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: directed vector table, reset-in-flight sequence and
// randomized accesses checked against a byte-level memory reference model.
module tb_lsu_mem_sequencer;
  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       busy_o;
  logic [2:0] dbg_state_o;

  always #5 clk_i = ~clk_i;

  lsu_core_if #(.XLEN(32)) core ();
  lsu_bus_if  #(.XLEN(32)) bus ();

  lsu_mem_sequencer #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .core        (core),
    .bus         (bus),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gd;
    int          rd;
    logic [31:0] pa0, pw0, pa1, pw1;
    int          nb;
    logic [31:0] ba[2];
    logic [3:0]  bbe[2];
    logic [31:0] bwd[2];
    bit          exact_wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic [31:0] exp_q[$];
  beat_t       beat_log[$];
  logic [7:0]  mem_b[logic [31:0]];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic mem_write_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
  endtask

  // Memory responder: grants after gnt_dly waiting cycles, answers rv_dly cycles after
  // the cycle following the grant. It deliberately ignores the sequencer's reset.
  initial begin : responder
    int          wcnt;
    int          rcnt;
    bit          pend;
    logic [31:0] rd;
    beat_t       first;
    wcnt = 0; rcnt = 0; pend = 0; rd = '0;
    first = '{we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
      if (pend) begin
        if (rcnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rd;
          pend = 0;
        end else rcnt--;
      end else if (bus.mem_req_o) begin
        if (wcnt == 0) first = '{we: bus.mem_we_o, be: bus.mem_be_o, addr: bus.mem_addr_o,
                                 wdata: bus.mem_wdata_o};
        if (wcnt >= gnt_dly) begin
          if (gnt_dly > 0)
            check("beat held stable", 96'({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}),
                  96'({first.we, first.be, first.addr, first.wdata}));
          bus.mem_gnt_i = 1'b1;
          wcnt = 0; pend = 1; rcnt = rv_dly;
          beat_log.push_back(first);
          for (int i = 0; i < 4; i++) rd[8*i +: 8] = byte_at(first.addr + 32'(i));
          if (first.we)
            for (int i = 0; i < 4; i++)
              if (first.be[i]) mem_b[first.addr + 32'(i)] = first.wdata[8*i +: 8];
        end else wcnt++;
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input int gd, input int rd,
                              input logic [31:0] pa0, input logic [31:0] pw0,
                              input logic [31:0] pa1, input logic [31:0] pw1, input int nb,
                              input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                              input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.gd = gd; v.rd = rd;
    v.pa0 = pa0; v.pw0 = pw0; v.pa1 = pa1; v.pw1 = pw1; v.nb = nb;
    v.ba[0] = a0; v.bbe[0] = be0; v.bwd[0] = wd0; v.ba[1] = a1; v.bbe[1] = be1; v.bwd[1] = wd1;
    v.exact_wd = 1'b1; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
    return v;
  endfunction

  // Reference: walk the accessed bytes one at a time; each distinct word they fall in is a beat.
  function automatic vec_t model_vec(input logic we, input logic [1:0] size, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input int gd, input int rd);
    vec_t        v;
    int          n;
    logic [31:0] a, wa, val;
    v = mk(we, size, uns, addr, wdata, gd, rd, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1);
    v.exact_wd = 1'b0;
    if (size == 2'd3) begin
      v.exp_err = 1'b1;
      return v;
    end
    n = 1 << size;
    val = '0;
    for (int i = 0; i < n; i++) begin
      a  = addr + 32'(i);
      wa = {a[31:2], 2'b00};
      if (v.nb == 0 || wa != v.ba[v.nb-1]) begin
        v.ba[v.nb] = wa; v.bbe[v.nb] = '0; v.bwd[v.nb] = '0;
        v.nb++;
      end
      v.bbe[v.nb-1][a[1:0]] = 1'b1;
      v.bwd[v.nb-1][8*int'(a[1:0]) +: 8] = wdata[8*i +: 8];
      val[8*i +: 8] = byte_at(a);
    end
    if (we)           v.exp_rdata = '0;
    else if (n == 1)  v.exp_rdata = uns ? {24'h0, val[7:0]} : {{24{val[7]}}, val[7:0]};
    else if (n == 2)  v.exp_rdata = uns ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
    else              v.exp_rdata = val;
    v.lat = 1 + v.nb * (gd + rd + 2);
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    int          cyc;
    bit          side_ok;
    logic [31:0] mask;
    beat_log.delete();
    gnt_dly = v.gd; rv_dly = v.rd;
    exp_q.push_back(v.exp_rdata);
    check({tag, " ready idle"}, 96'(core.req_ready_o), 96'(1));
    core.req_valid_i = 1'b1; core.req_we_i = v.we; core.req_size_i = v.size;
    core.req_unsigned_i = v.uns; core.req_addr_i = v.addr; core.req_wdata_i = v.wdata;
    @(posedge clk_i); #1;
    core.req_valid_i = 1'b0; core.req_we_i = 1'($urandom); core.req_size_i = 2'($urandom);
    core.req_unsigned_i = 1'($urandom); core.req_addr_i = $urandom; core.req_wdata_i = $urandom;
    cyc = 1; side_ok = 1;
    while (!core.rsp_valid_o && cyc < 200) begin
      if (core.req_ready_o !== 1'b0 || busy_o !== 1'b1) side_ok = 0;
      if (core.rsp_rdata_o !== '0 || core.rsp_err_o !== 1'b0) side_ok = 0;
      if (!bus.mem_req_o && (bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== '0 ||
                             bus.mem_be_o !== '0 || bus.mem_wdata_o !== '0)) side_ok = 0;
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, " latency"}, 96'(cyc), 96'(v.lat));
    check({tag, " rdata"}, 96'(core.rsp_rdata_o), 96'(exp_q.pop_front()));
    check({tag, " err"}, 96'(core.rsp_err_o), 96'(v.exp_err));
    check({tag, " resp busy/ready/mem_req"}, 96'({busy_o, core.req_ready_o, bus.mem_req_o}), 96'(3'b100));
    check({tag, " busy and idle bus while pending"}, 96'(side_ok), 96'(1));
    @(posedge clk_i); #1;
    check({tag, " single pulse"}, 96'({core.rsp_valid_o, core.req_ready_o, busy_o, core.rsp_err_o}),
          96'(4'b0100));
    check({tag, " beat count"}, 96'(beat_log.size()), 96'(v.nb));
    for (int i = 0; i < 2; i++) begin
      if (i < v.nb && i < beat_log.size()) begin
        check({tag, " beat addr"}, 96'(beat_log[i].addr), 96'(v.ba[i]));
        check({tag, " beat be/we"}, 96'({beat_log[i].be, beat_log[i].we}), 96'({v.bbe[i], v.we}));
        if (v.we) begin
          for (int b = 0; b < 4; b++) mask[8*b +: 8] = (v.exact_wd || v.bbe[i][b]) ? 8'hFF : 8'h00;
          check({tag, " beat wdata"}, 96'(beat_log[i].wdata & mask), 96'(v.bwd[i] & mask));
        end
      end
    end
  endtask

  vec_t tbl[10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        v;
    bit          quiet_ok;
    int          s;
    logic [31:0] addr;
    rst_ni = 1'b0;
    core.req_valid_i = 1'b0; core.req_we_i = 1'b0; core.req_size_i = 2'd0;
    core.req_unsigned_i = 1'b0; core.req_addr_i = '0; core.req_wdata_i = '0;

    #3;
    check("reset outputs", 96'({core.req_ready_o, busy_o, bus.mem_req_o, core.rsp_valid_o,
                                core.rsp_err_o, bus.mem_we_o, bus.mem_be_o}), 96'(10'b10_0000_0000));
    check("reset data outputs", 96'({core.rsp_rdata_o, bus.mem_addr_o, bus.mem_wdata_o}), 96'(0));
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    //            we    sz uns addr          wdata         gd rd preload0                 preload1                 nb beat0                               beat1                              rdata         err lat
    tbl[0] = mk(1'b0, 2, 0, 32'h0000_0100, 32'h0,        0, 0, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 1, 32'h100, 4'b1111, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 0, 3);
    tbl[1] = mk(1'b0, 0, 0, 32'h0000_0103, 32'h0,        0, 0, 32'h100, 32'h80FF0000, 32'h100, 32'h80FF0000, 1, 32'h100, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80, 0, 3);
    tbl[2] = mk(1'b0, 0, 1, 32'h0000_0103, 32'h0,        0, 0, 32'h100, 32'h80FF0000, 32'h100, 32'h80FF0000, 1, 32'h100, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h00000080, 0, 3);
    tbl[3] = mk(1'b1, 1, 0, 32'h0000_0202, 32'h1234ABCD, 0, 0, 32'h200, 32'h0,        32'h200, 32'h0,        1, 32'h200, 4'b1100, 32'hABCD0000, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 3);
    tbl[4] = mk(1'b0, 2, 0, 32'h0000_0FFF, 32'h0,        0, 0, 32'hFFC, 32'h11223344, 32'h1000, 32'h55667788, 2, 32'hFFC, 4'b1000, 32'h0, 32'h1000, 4'b0111, 32'h0, 32'h66778811, 0, 5);
    tbl[5] = mk(1'b1, 2, 0, 32'hFFFF_FFFE, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0,        32'h0,   32'h0,        2, 32'hFFFFFFFC, 4'b1100, 32'hF00D0000, 32'h0, 4'b0011, 32'h0000CAFE, 32'h0, 0, 5);
    tbl[6] = mk(1'b0, 1, 0, 32'h0000_0106, 32'h0,        3, 1, 32'h104, 32'h80017FFF, 32'h104, 32'h80017FFF, 1, 32'h104, 4'b1100, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001, 0, 7);
    tbl[7] = mk(1'b0, 3, 0, 32'h0000_0040, 32'h0,        0, 0, 32'h40,  32'h0,        32'h40,  32'h0,        0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 1);
    tbl[8] = mk(1'b0, 1, 1, 32'h0000_0203, 32'h0,        0, 0, 32'h200, 32'hAB000000, 32'h204, 32'h000000CD, 2, 32'h200, 4'b1000, 32'h0, 32'h204, 4'b0001, 32'h0, 32'h0000CDAB, 0, 5);
    tbl[9] = mk(1'b0, 1, 0, 32'h0000_0203, 32'h0,        1, 2, 32'h200, 32'hAB000000, 32'h204, 32'h000000CD, 2, 32'h200, 4'b1000, 32'h0, 32'h204, 4'b0001, 32'h0, 32'hFFFFCDAB, 0, 11);

    for (int i = 0; i < 10; i++) begin
      mem_write_word(tbl[i].pa0, tbl[i].pw0);
      mem_write_word(tbl[i].pa1, tbl[i].pw1);
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while beat0 is outstanding; the late rvalid must not produce a response.
    beat_log.delete();
    gnt_dly = 0; rv_dly = 3;
    core.req_valid_i = 1'b1; core.req_we_i = 1'b0; core.req_size_i = 2'd2;
    core.req_unsigned_i = 1'b0; core.req_addr_i = 32'h100; core.req_wdata_i = '0;
    @(posedge clk_i); #1;
    core.req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst in wait0 busy", 96'({busy_o, core.req_ready_o, bus.mem_req_o}), 96'(3'b100));
    #2 rst_ni = 1'b0;
    #1;
    check("rst async outputs", 96'({core.req_ready_o, busy_o, bus.mem_req_o, core.rsp_valid_o,
                                    core.rsp_err_o, bus.mem_be_o}), 96'(9'b1_0000_0000));
    check("rst async rdata/addr", 96'({core.rsp_rdata_o, bus.mem_addr_o}), 96'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    quiet_ok = 1;
    for (int i = 0; i < 8; i++) begin
      if (core.rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || bus.mem_req_o !== 1'b0) quiet_ok = 0;
      @(posedge clk_i); #1;
    end
    check("late rvalid ignored after reset", 96'(quiet_ok), 96'(1));

    for (int t = 0; t < 150; t++) begin
      s = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           addr = 32'h100 + 32'($urandom_range(0, 255));
      v = model_vec(1'($urandom), (s == 9) ? 2'd3 : 2'(s % 3), 1'($urandom), addr, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2));
      apply_vec(v, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_mem_sequencer.md
Name: lsu_mem_sequencer

Overview:
Multi-cycle sequencer between the core's load/store stage and a single-port data-memory bus with req/gnt/rvalid handshake. Takes one byte-addressed load/store at a time. Aligns data to bus lanes and generates byte strobes. Splits word-crossing misaligned accesses into two bus beats, then merges and sign/zero-extends load data. Gives a one-cycle response to the core.

Parameters:
XLEN, 32, data/address width; NB = XLEN/8 byte lanes (only 32 is verified).

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  sequencer can accept (IDLE only)
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned_i  in  1  zero-extend load (LBU/LHU)
req_addr_i  in  XLEN  byte address
req_wdata_i  in  XLEN  store data, right-justified
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  XLEN  extended load data (0 for stores)
rsp_err_o  out  1  illegal size
mem_req_o  out  1  bus request
mem_gnt_i  in  1  bus grant
mem_we_o  out  1  bus write
mem_addr_o  out  XLEN  word-aligned address (low log2(NB) bits 0)
mem_be_o  out  NB  byte enables
mem_wdata_o  out  XLEN  lane-shifted write data
mem_rvalid_i  in  1  beat completion (read data or store ack)
mem_rdata_i  in  XLEN  read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_ni=0): state IDLE. All outputs 0 except req_ready_o=1. Captured request discarded. An in-flight bus beat is abandoned; late rvalid after reset is ignored in IDLE.
- Acceptance: req_valid_i && req_ready_o. Captures we, size, unsigned, addr, wdata. off = addr[1:0]; bytes = 1/2/4; split = (off+bytes > 4).
- Base BE: 0001/0011/1111 per size. Beat0: addr&~3, BE = (base<<off)[3:0], wdata<<8*off. Beat1: (addr&~3)+4, wrapping mod 2^XLEN; BE = base>>(4-off), wdata>>8*(4-off).
- FSM: IDLE -> REQ0 on accept (size 3 -> RESP with err=1, no bus access).
- REQ0: mem_req_o=1 with beat0 fields held stable; on mem_gnt_i -> WAIT0.
- WAIT0: mem_req_o=0; on mem_rvalid_i capture rdata0; -> REQ1 if split, else RESP.
- REQ1/WAIT1: same as REQ0/WAIT0 for beat1; capture rdata1; -> RESP.
- RESP: rsp_valid_o=1 for exactly one cycle -> IDLE. No core backpressure.
- Bus ordering: at most one outstanding beat. rvalid arriving in REQx or IDLE is ignored. gnt outside REQx is ignored. mem_* fields are registered, change only on state entry, and are 0 in IDLE/WAITx/RESP.
- Load merge: raw = {rdata1,rdata0} >> 8*off (rdata1=0 if not split). Take the low 8/16/32 bits. Sign-extend unless req_unsigned_i. Stores return rsp_rdata_o=0.
- Latency with gnt in the first REQ cycle and rvalid the cycle after gnt: rsp_valid_o 3 cycles after acceptance (aligned), 5 (split), 1 (illegal). Each gnt/rvalid wait cycle adds one.
- rsp_rdata_o/rsp_err_o are valid only with rsp_valid_o and are 0 otherwise.

Test Plan:
- LW addr 0x100, mem returns 0xDEADBEEF, zero-wait bus -> mem_addr 0x100, be 1111; rsp_valid 3 cycles after accept, rdata 0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_0000 (signed), then LBU -> be 1000; rdata 0xFFFFFF80, then 0x00000080.
- SH addr 0x0202, wdata 0x1234ABCD -> be 1100, mem_wdata 0xABCD0000, we=1; rsp rdata 0.
- LW misaligned addr 0x0FFF, beat0 rdata 0x11223344, beat1 0x55667788 -> beats at 0x0FFC/be 1000 then 0x1000/be 0111; rdata 0x66778811 at 5 cycles. Also SW 0xFFFFFFFE: beat1 addr wraps to 0x00000000.
- Bus stalls: gnt delayed 3 cycles, rvalid 2 cycles after gnt -> mem_req/addr/be stable until gnt; req_ready_o=0 and busy_o=1 throughout; single rsp pulse.
- size=3 -> no mem_req, rsp_valid next cycle with err=1. rst_ni low in WAIT0 -> immediate IDLE, outputs 0, later rvalid produces no rsp.
